// File: rtl/dcache_pkg.sv
// Shared encodings, FSM state type and lane helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0]  strb;
    logic [31:0] data;
  } store_lanes_t;

  // Offset bits above the access size are ignored, so misaligned halves/words wrap silently.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  offset,
                                              input logic [2:0]  funct3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_BU:   r = {24'd0, b};
      F3_HU:   r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic store_lanes_t store_lanes(input logic [31:0] wdata,
                                               input logic [1:0]  offset,
                                               input logic [2:0]  funct3);
    store_lanes_t s;
    case (funct3)
      F3_B: begin
        s.strb = 4'b0001 << offset;
        s.data = {4{wdata[7:0]}};
      end
      F3_H: begin
        s.strb = offset[1] ? 4'b1100 : 4'b0011;
        s.data = {2{wdata[15:0]}};
      end
      default: begin
        s.strb = 4'b1111;
        s.data = wdata;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache: async-cleared valid bits,
// combinational read, one write port used for line fills or strobed store merges.
module dcache_array #(
  parameter int LINES   = 64,
  parameter int INDEX_W = $clog2(LINES),
  parameter int TAG_W   = 32 - INDEX_W - 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic               fill_en,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [31:0]        fill_data,
  input  logic               merge_en,
  input  logic [3:0]         merge_strb,
  input  logic [31:0]        merge_data
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;
  logic [TAG_W-1:0] tag_mem [LINES];

  always_comb begin
    valid_d = valid_q;
    if (fill_en) valid_d[wr_index] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (fill_en) tag_mem[wr_index] <= fill_tag;
  end

  // One byte-wide array per lane so each lane can be written independently.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [LINES];
    always_ff @(posedge clk) begin
      if (fill_en)
        lane_mem[wr_index] <= fill_data[8*gi +: 8];
      else if (merge_en && merge_strb[gi])
        lane_mem[wr_index] <= merge_data[8*gi +: 8];
    end
    assign rd_data[8*gi +: 8] = lane_mem[rd_index];
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache for the M stage.
// Optional DCACHE_STATS_EN adds hit_count/miss_count outputs.
module dcache_direct
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 64,
  parameter int INDEX_W    = $clog2(LINES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           aluresultM,
  input  logic                  memreadM,
  input  logic                  memwriteM,
  input  logic [2:0]            funct3M,
  input  logic [DATA_WIDTH-1:0] writedataM,
  output logic [DATA_WIDTH-1:0] readdataM,
  output logic                  stallM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int TAG_W = 32 - INDEX_W - 2;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        wr_done_q, wr_done_d;

  logic [INDEX_W-1:0] look_index;
  logic [TAG_W-1:0]   look_tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [31:0]        rd_data;
  logic               hit;
  logic               fill_en;
  logic               merge_en;
  store_lanes_t       lanes;

  // While a transaction is open, look up the latched address so the hit test
  // at ack time is independent of what the pipeline presents.
  assign look_index = (state_q == IDLE) ? aluresultM[INDEX_W+1:2] : mem_addr_q[INDEX_W+1:2];
  assign look_tag   = (state_q == IDLE) ? aluresultM[31:INDEX_W+2] : mem_addr_q[31:INDEX_W+2];
  assign hit        = rd_valid && (rd_tag == look_tag);
  assign lanes      = store_lanes(writedataM, aluresultM[1:0], funct3M);

  dcache_array #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (look_index),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_index   (mem_addr_q[INDEX_W+1:2]),
    .fill_en    (fill_en),
    .fill_tag   (mem_addr_q[31:INDEX_W+2]),
    .fill_data  (mem_rdata),
    .merge_en   (merge_en),
    .merge_strb (mem_wstrb_q),
    .merge_data (mem_wdata_q)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    wr_done_d   = 1'b0;
    fill_en     = 1'b0;
    merge_en    = 1'b0;
    stallM      = 1'b0;
    readdataM   = '0;
    case (state_q)
      IDLE: begin
        // wr_done_q marks the release cycle of a finished store still sitting in M.
        if (memwriteM && !wr_done_q) begin
          stallM      = 1'b1;
          state_d     = WR_THRU;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {aluresultM[31:2], 2'b00};
          mem_wdata_d = lanes.data;
          mem_wstrb_d = lanes.strb;
        end else if (memreadM && !memwriteM) begin
          if (hit) begin
            readdataM = load_extend(rd_data, aluresultM[1:0], funct3M);
          end else begin
            stallM      = 1'b1;
            state_d     = RD_MISS;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = {aluresultM[31:2], 2'b00};
            mem_wstrb_d = 4'b0000;
          end
        end
      end
      RD_MISS: begin
        stallM = 1'b1;
        if (mem_ack) begin
          fill_en   = 1'b1;
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      WR_THRU: begin
        stallM = 1'b1;
        if (mem_ack) begin
          merge_en    = hit;
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          wr_done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        hit_load;
  logic        miss_start;

  assign hit_load   = (state_q == IDLE) && memreadM && !memwriteM && hit;
  assign miss_start = (state_q == IDLE) && (state_d == RD_MISS);

  always_comb begin
    hit_count_d  = hit_count_q + {31'd0, hit_load};
    miss_count_d = miss_count_q + {31'd0, miss_start};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// Scoreboard bench for dcache_direct: stimulus pushes expected loads/requests,
// a negedge monitor pops and compares them; a small backing-RAM model answers requests.
module tb_dcache_direct;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] aluresultM;
  logic        memreadM;
  logic        memwriteM;
  logic [2:0]  funct3M;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  always #5 clk = ~clk;

  dcache_direct dut (
    .clk        (clk),
`ifdef DCACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .rst        (rst),
    .aluresultM (aluresultM),
    .memreadM   (memreadM),
    .memwriteM  (memwriteM),
    .funct3M    (funct3M),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    string       name;
    logic [31:0] val;
  } ld_t;

  req_t req_q[$];
  ld_t  load_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ram [0:255];
  bit          resp_en = 1'b1;
  int          wait_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Backing RAM: acknowledges the third cycle a request is seen.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req && resp_en && !rst) begin
        wait_cnt++;
        if (wait_cnt == 3) begin
          wait_cnt = 0;
          mem_ack  = 1'b1;
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) ram[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            mem_rdata = '0;
          end else begin
            mem_rdata = ram[mem_addr[9:2]];
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: completed loads and new backing-RAM requests.
  initial begin
    logic req_prev;
    ld_t  ld;
    req_t r;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && memreadM && !stallM) begin
        if (load_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: got 0x%08h expected no load", readdataM);
        end else begin
          ld = load_q.pop_front();
          check(ld.name, readdataM, ld.val);
        end
      end
      if (mem_req && !req_prev) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr 0x%08h expected no request", mem_addr);
        end else begin
          r = req_q.pop_front();
          check({r.name, "_addr"}, mem_addr, r.addr);
          check({r.name, "_we"}, {31'd0, mem_we}, {31'd0, r.we});
          if (r.we) begin
            check({r.name, "_wstrb"}, {28'd0, mem_wstrb}, {28'd0, r.strb});
            check({r.name, "_wdata"}, mem_wdata, r.wdata);
          end
        end
      end
      req_prev = mem_req;
    end
  end

  task automatic do_load(input string name, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] exp, input bit expect_hit);
    int cycles;
    load_q.push_back('{name, exp});
    if (!expect_hit) req_q.push_back('{{name, "_rd"}, {addr[31:2], 2'b00}, 1'b0, 4'b0000, 32'd0});
    aluresultM = addr;
    funct3M    = f3;
    memreadM   = 1'b1;
    cycles     = 0;
    forever begin
      @(negedge clk);
      if (!stallM) break;
      cycles++;
      if (cycles > 50) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: got stallM=1 for %0d cycles expected release", name, cycles);
        break;
      end
    end
    if (expect_hit) check({name, "_hitlat"}, cycles, 0);
    else            check({name, "_missstall"}, {31'd0, cycles != 0}, 32'd1);
    @(posedge clk);
    #1;
    memreadM = 1'b0;
  endtask

  task automatic do_store(input string name, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] data, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata);
    int cycles;
    req_q.push_back('{name, {addr[31:2], 2'b00}, 1'b1, exp_strb, exp_wdata});
    aluresultM = addr;
    funct3M    = f3;
    writedataM = data;
    memwriteM  = 1'b1;
    cycles     = 0;
    forever begin
      @(negedge clk);
      if (!stallM) break;
      cycles++;
      if (cycles > 50) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: got stallM=1 for %0d cycles expected release", name, cycles);
        break;
      end
    end
    check({name, "_stalled"}, {31'd0, cycles != 0}, 32'd1);
    @(posedge clk);
    #1;
    memwriteM = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    ram[8'h40] = 32'hDEADBEEF;
    ram[8'h80] = 32'h0BADF00D;
    ram[8'hC0] = 32'h33333333;

    rst        = 1'b1;
    aluresultM = '0;
    memreadM   = 1'b0;
    memwriteM  = 1'b0;
    funct3M    = '0;
    writedataM = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_stallM", {31'd0, stallM}, 32'd0);
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_readdataM", readdataM, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    @(posedge clk);
    #1;

    do_load("cold_lw_100", 32'h100, F3_W, 32'hDEADBEEF, 1'b0);
    do_load("hit_lw_100", 32'h100, F3_W, 32'hDEADBEEF, 1'b1);
    do_store("sw_100", 32'h100, F3_W, 32'h80FF7F01, 4'b1111, 32'h80FF7F01);
    do_load("lb_103", 32'h103, F3_B, 32'hFFFFFF80, 1'b1);
    do_load("lbu_103", 32'h103, F3_BU, 32'h00000080, 1'b1);
    do_load("lh_102", 32'h102, F3_H, 32'hFFFF80FF, 1'b1);
    do_load("lhu_100", 32'h100, F3_HU, 32'h00007F01, 1'b1);
    do_store("sb_101", 32'h101, F3_B, 32'h000000AA, 4'b0010, 32'hAAAAAAAA);
    do_load("lw_100_merged", 32'h100, F3_W, 32'h80FFAA01, 1'b1);
    do_store("sw_200_miss", 32'h200, F3_W, 32'h5555AAAA, 4'b1111, 32'h5555AAAA);
    do_load("lw_200_alias", 32'h200, F3_W, 32'h5555AAAA, 1'b0);
    do_load("lw_100_evicted", 32'h100, F3_W, 32'h80FFAA01, 1'b0);
    do_store("sh_102", 32'h102, F3_H, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF);
    do_load("lhu_102", 32'h102, F3_HU, 32'h0000BEEF, 1'b1);
    do_load("lh_100", 32'h100, F3_H, 32'hFFFFAA01, 1'b1);
    do_load("lbu_101", 32'h101, F3_BU, 32'h000000AA, 1'b1);
    do_load("lb_100", 32'h100, F3_B, 32'h00000001, 1'b1);

    // Reset while a read miss is outstanding.
    resp_en = 1'b0;
    req_q.push_back('{"rst_lw_300", 32'h300, 1'b0, 4'b0000, 32'd0});
    aluresultM = 32'h300;
    funct3M    = F3_W;
    memreadM   = 1'b1;
    cnt = 0;
    while (!mem_req && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_miss_req_up", {31'd0, mem_req}, 32'd1);
    @(posedge clk);
    #2;
    rst      = 1'b1;
    memreadM = 1'b0;
    #1;
    check("rst_req_drop", {31'd0, mem_req}, 32'd0);
    check("rst_stall_drop", {31'd0, stallM}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #2;
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    @(negedge clk);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check("late_ack_ignored_req", {31'd0, mem_req}, 32'd0);
    check("late_ack_ignored_stall", {31'd0, stallM}, 32'd0);
    resp_en = 1'b1;
    @(posedge clk);
    #1;
    do_load("post_rst_lw_100", 32'h100, F3_W, 32'hBEEFAA01, 1'b0);

    repeat (3) @(posedge clk);
    check("load_q_drained", load_q.size(), 32'd0);
    check("req_q_drained", req_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
